// File: rtl/div_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_arbiter_if: requester and divider handshake bundle for the       |
// | shared divider arbiter.                                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface div_arbiter_if #(
   parameter int NUM_REQ        = 4,
   parameter int DIVIDEND_WIDTH = 64,
   parameter int DIVISOR_WIDTH  = 32
);
   localparam int c_ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0]                req_ready;
   logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend;
   logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor;
   logic [NUM_REQ-1:0]                rsp_valid;
   logic [DIVIDEND_WIDTH-1:0]         rsp_quotient;
   logic [DIVISOR_WIDTH-1:0]          rsp_remainder;
   logic                              rsp_overflow;
   logic                              div_valid_in;
   logic [DIVIDEND_WIDTH-1:0]         div_dividend;
   logic [DIVISOR_WIDTH-1:0]          div_divisor;
   logic                              div_valid_out;
   logic [DIVIDEND_WIDTH-1:0]         div_quotient;
   logic [DIVISOR_WIDTH-1:0]          div_remainder;
   logic                              div_overflow;
   logic                              busy;
   logic [c_ID_W-1:0]                 grant_id;

   modport slave (
      input  req_valid, req_dividend, req_divisor,
      input  div_valid_out, div_quotient, div_remainder, div_overflow,
      output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
      output div_valid_in, div_dividend, div_divisor, busy, grant_id
   );

   modport master (
      output req_valid, req_dividend, req_divisor,
      output div_valid_out, div_quotient, div_remainder, div_overflow,
      input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
      input  div_valid_in, div_dividend, div_divisor, busy, grant_id
   );
endinterface
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_arbiter: round-robin sharing of one multi-cycle divider among    |
// | NUM_REQ requesters, with local trapping of zero divisors.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DIVIDEND_WIDTH = 64,
   parameter int DIVISOR_WIDTH  = 32
) (
   input wire logic     clk,
   input wire logic     reset,
   div_arbiter_if.slave bus
);
   localparam int c_ID_W  = $clog2(NUM_REQ);
   localparam int c_SUM_W = c_ID_W + 1;
   localparam logic [NUM_REQ-1:0] c_ONE = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t                    r_state;
   logic [c_ID_W-1:0]         r_ptr;
   logic [c_ID_W-1:0]         r_grant_id;
   logic [DIVIDEND_WIDTH-1:0] r_div_dividend;
   logic [DIVISOR_WIDTH-1:0]  r_div_divisor;
   logic [DIVIDEND_WIDTH-1:0] r_rsp_quotient;
   logic [DIVISOR_WIDTH-1:0]  r_rsp_remainder;
   logic                      r_rsp_overflow;
   logic [NUM_REQ-1:0]        r_rsp_valid;
   logic                      r_div_valid_in;
   logic                      r_busy;

   logic [DIVIDEND_WIDTH-1:0] w_dividend [NUM_REQ];
   logic [DIVISOR_WIDTH-1:0]  w_divisor  [NUM_REQ];
   logic [c_SUM_W-1:0]        w_sum;
   logic                      w_found;
   logic                      w_accept;
   logic [c_ID_W-1:0]         w_winner;
   logic [c_ID_W-1:0]         w_next_ptr;
   logic [NUM_REQ-1:0]        w_win_onehot;
   logic [DIVIDEND_WIDTH-1:0] w_sel_dividend;
   logic [DIVISOR_WIDTH-1:0]  w_sel_divisor;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_dividend[gi] = bus.req_dividend[gi*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
         assign w_divisor[gi]  = bus.req_divisor[gi*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
   endgenerate

   // Scan from the far end back toward ptr so the closest requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + c_SUM_W'(k);
         if (w_sum >= c_SUM_W'(NUM_REQ)) begin
            w_sum = w_sum - c_SUM_W'(NUM_REQ);
         end
         if (bus.req_valid[w_sum[c_ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[c_ID_W-1:0];
         end
      end
   end

   assign w_accept       = reset && (r_state == S_IDLE) && w_found;
   assign w_win_onehot   = c_ONE << w_winner;
   assign w_sel_dividend = w_dividend[w_winner];
   assign w_sel_divisor  = w_divisor[w_winner];
   assign w_next_ptr     = (w_winner == c_ID_W'(NUM_REQ - 1)) ? '0 : w_winner + c_ID_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_ptr           <= '0;
         r_grant_id      <= '0;
         r_div_dividend  <= '0;
         r_div_divisor   <= '0;
         r_rsp_quotient  <= '0;
         r_rsp_remainder <= '0;
         r_rsp_overflow  <= 1'b0;
         r_rsp_valid     <= '0;
         r_div_valid_in  <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_div_dividend <= w_sel_dividend;
                  r_div_divisor  <= w_sel_divisor;
                  r_grant_id     <= w_winner;
                  r_ptr          <= w_next_ptr;
                  r_busy         <= 1'b1;
                  if (w_sel_divisor != '0) begin
                     r_div_valid_in <= 1'b1;
                     r_state        <= S_ISSUE;
                  end else begin
                     // Zero divisor: answer locally, the divider never starts.
                     r_rsp_quotient  <= '1;
                     r_rsp_remainder <= w_sel_dividend[DIVISOR_WIDTH-1:0];
                     r_rsp_overflow  <= 1'b1;
                     r_rsp_valid     <= w_win_onehot;
                     r_state         <= S_RESP;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.div_valid_out) begin
                  r_rsp_quotient  <= bus.div_quotient;
                  r_rsp_remainder <= bus.div_remainder;
                  r_rsp_overflow  <= bus.div_overflow;
                  r_rsp_valid     <= c_ONE << r_grant_id;
                  r_div_valid_in  <= 1'b0;
                  r_state         <= S_RESP;
               end
            end
            S_RESP: begin
               r_rsp_valid <= '0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_rsp_valid    <= '0;
               r_div_valid_in <= 1'b0;
               r_busy         <= 1'b0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready     = w_accept ? w_win_onehot : '0;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_quotient  = r_rsp_quotient;
   assign bus.rsp_remainder = r_rsp_remainder;
   assign bus.rsp_overflow  = r_rsp_overflow;
   assign bus.div_valid_in  = r_div_valid_in;
   assign bus.div_dividend  = r_div_dividend;
   assign bus.div_divisor   = r_div_divisor;
   assign bus.busy          = r_busy;
   assign bus.grant_id      = r_grant_id;
endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_arbiter: directed bench with a behavioural divider model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_div_arbiter;
   localparam int N   = 4;
   localparam int A_W = 64;
   localparam int B_W = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   div_arbiter_if #(.NUM_REQ(N), .DIVIDEND_WIDTH(A_W), .DIVISOR_WIDTH(B_W)) bus ();

   div_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(A_W), .DIVISOR_WIDTH(B_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_checks  = 0;
   int   n_fail    = 0;
   int   div_lat   = 3;
   logic force_ovf = 1'b0;
   logic spur      = 1'b0;

   // Divider model: latches operands on valid_in, answers div_lat cycles later.
   logic           m_busy, m_vout, m_o;
   int             m_cnt;
   logic [A_W-1:0] m_a, m_q;
   logic [B_W-1:0] m_b, m_r;

   assign bus.div_valid_out = m_vout | spur;
   assign bus.div_quotient  = m_q;
   assign bus.div_remainder = m_r;
   assign bus.div_overflow  = m_o;

   always @(posedge clk) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_vout <= 1'b0;
         m_cnt  <= 0;
         m_q    <= '0;
         m_r    <= '0;
         m_o    <= 1'b0;
      end else begin
         m_vout <= 1'b0;
         if (m_busy) begin
            if (m_cnt <= 1) begin
               m_vout <= 1'b1;
               m_q    <= m_a / {32'b0, m_b};
               m_r    <= 32'(m_a % {32'b0, m_b});
               m_o    <= force_ovf;
               m_busy <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (bus.div_valid_in && !m_vout) begin
            m_busy <= 1'b1;
            m_cnt  <= div_lat;
            m_a    <= bus.div_dividend;
            m_b    <= bus.div_divisor;
         end
      end
   end

   typedef struct {
      int             rq;
      logic [A_W-1:0] dvd;
      logic [B_W-1:0] dvs;
      logic           fovf;
      logic [A_W-1:0] eq;
      logic [B_W-1:0] er;
      logic           eo;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      check({tag, "_div_valid_in"}, 64'(bus.div_valid_in), 64'd0);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_rsp_overflow"}, 64'(bus.rsp_overflow), 64'd0);
      check({tag, "_rsp_quotient"}, bus.rsp_quotient, 64'd0);
      check({tag, "_rsp_remainder"}, 64'(bus.rsp_remainder), 64'd0);
      check({tag, "_div_dividend"}, bus.div_dividend, 64'd0);
      check({tag, "_div_divisor"}, 64'(bus.div_divisor), 64'd0);
      check({tag, "_grant_id"}, 64'(bus.grant_id), 64'd0);
   endtask

   task automatic wait_ready(output logic [N-1:0] g);
      int n = 0;
      #1;
      while (bus.req_ready == '0 && n < 100) begin
         step();
         n++;
      end
      check("ready_timeout", 64'(n < 100), 64'd1);
      g = bus.req_ready;
   endtask

   // Waits for the strobe, checks the result, then checks it lasts one cycle.
   task automatic wait_rsp(input int id, input logic [A_W-1:0] eq, input logic [B_W-1:0] er,
                           input logic eo);
      int n = 0;
      logic [N-1:0] oh;
      oh = 4'b0001 << id;
      while (bus.rsp_valid == '0 && n < 100) begin
         step();
         n++;
      end
      check("rsp_timeout", 64'(n < 100), 64'd1);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      check("rsp_grant_id", 64'(bus.grant_id), 64'(id));
      check("rsp_quotient", bus.rsp_quotient, eq);
      check("rsp_remainder", 64'(bus.rsp_remainder), 64'(er));
      check("rsp_overflow", 64'(bus.rsp_overflow), 64'(eo));
      check("rsp_div_valid_in", 64'(bus.div_valid_in), 64'd0);
      step();
      check("rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);
      check("busy_after_rsp", 64'(bus.busy), 64'd0);
      check("rsp_hold", bus.rsp_quotient, eq);
   endtask

   task automatic run_op(input vec_t v);
      logic [N-1:0] oh;
      oh = 4'b0001 << v.rq;
      step();
      bus.req_dividend[v.rq*A_W +: A_W] = v.dvd;
      bus.req_divisor[v.rq*B_W +: B_W]  = v.dvs;
      force_ovf     = v.fovf;
      bus.req_valid = oh;
      #1;
      check("op_req_ready", 64'(bus.req_ready), 64'(oh));
      step();
      bus.req_valid = '0;
      check("op_busy", 64'(bus.busy), 64'd1);
      if (v.dvs == '0) begin
         check("zero_no_issue", 64'(bus.div_valid_in), 64'd0);
         check("zero_rsp_next", 64'(bus.rsp_valid), 64'(oh));
      end else begin
         check("issue_valid_in", 64'(bus.div_valid_in), 64'd1);
         check("issue_dividend", bus.div_dividend, v.dvd);
         check("issue_divisor", 64'(bus.div_divisor), 64'(v.dvs));
      end
      wait_rsp(v.rq, v.eq, v.er, v.eo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] g;
      logic [A_W-1:0] cq [4];
      logic [B_W-1:0] cr [4];
      int n;
      bit saw;

      vecs[0] = '{0, 64'd253, 32'd2, 1'b0, 64'd126, 32'd1, 1'b0};
      vecs[1] = '{1, 64'd1000, 32'd7, 1'b0, 64'd142, 32'd6, 1'b0};
      vecs[2] = '{2, 64'h1_0000_0005, 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 1'b1};
      vecs[3] = '{3, 64'd5, 32'd9, 1'b0, 64'd0, 32'd5, 1'b0};
      vecs[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0};
      vecs[5] = '{1, 64'd100, 32'd10, 1'b1, 64'd10, 32'd0, 1'b1};
      vecs[6] = '{3, 64'd0, 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b1};
      vecs[7] = '{2, 64'h1_0000_0000, 32'h10, 1'b0, 64'h1000_0000, 32'd0, 1'b0};
      vecs[8] = '{1, 64'd12345, 32'hFFFF_FFFF, 1'b0, 64'd0, 32'd12345, 1'b0};
      cq = '{64'd2, 64'd35, 64'd69, 64'd102};
      cr = '{32'd1, 32'd2, 32'd0, 32'd1};

      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      reset = 1'b0;
      repeat (3) step();
      check_reset("init");
      reset = 1'b1;
      step();

      // Contention from a fresh pointer: grants in index order.
      for (int i = 0; i < N; i++) begin
         bus.req_dividend[i*A_W +: A_W] = 64'(i*100 + 7);
         bus.req_divisor[i*B_W +: B_W]  = 32'd3;
      end
      bus.req_valid = 4'hF;
      for (int k = 0; k < N; k++) begin
         wait_ready(g);
         check("cont_grant", 64'(g), 64'(4'b0001 << k));
         step();
         bus.req_valid[k] = 1'b0;
         wait_rsp(k, cq[k], cr[k], 1'b0);
      end

      // Fairness: req 1 re-requests after each response, req 3 holds.
      bus.req_dividend[1*A_W +: A_W] = 64'd50;
      bus.req_divisor[1*B_W +: B_W]  = 32'd5;
      bus.req_dividend[3*A_W +: A_W] = 64'd77;
      bus.req_divisor[3*B_W +: B_W]  = 32'd4;
      bus.req_valid = 4'b1010;
      for (int j = 0; j < 4; j++) begin
         int e;
         e = (j % 2 == 0) ? 1 : 3;
         wait_ready(g);
         check("fair_grant", 64'(g), 64'(4'b0001 << e));
         step();
         if (j == 3) bus.req_valid = '0;
         else if (e == 1) bus.req_valid[1] = 1'b0;
         if (e == 1) wait_rsp(1, 64'd10, 32'd0, 1'b0);
         else        wait_rsp(3, 64'd19, 32'd1, 1'b0);
         if (e == 1 && j < 3) bus.req_valid[1] = 1'b1;
      end

      for (int v = 0; v < 9; v++) run_op(vecs[v]);
      force_ovf = 1'b0;

      // A stray divider strobe while idle must be ignored.
      step();
      spur = 1'b1;
      step();
      spur = 1'b0;
      check("spur_busy", 64'(bus.busy), 64'd0);
      check("spur_rsp", 64'(bus.rsp_valid), 64'd0);
      step();
      check("spur_rsp_late", 64'(bus.rsp_valid), 64'd0);

      // Back-to-back from requester 0.
      bus.req_dividend[0 +: A_W] = 64'd900;
      bus.req_divisor[0 +: B_W]  = 32'd30;
      bus.req_valid = 4'b0001;
      wait_ready(g);
      check("b2b_grant1", 64'(g), 64'd1);
      step();
      bus.req_dividend[0 +: A_W] = 64'd901;
      bus.req_divisor[0 +: B_W]  = 32'd2;
      n = 0;
      while (!bus.div_valid_out && n < 100) begin
         step();
         n++;
      end
      check("b2b_vout_timeout", 64'(n < 100), 64'd1);
      check("b2b_vin_at_vout", 64'(bus.div_valid_in), 64'd1);
      step();
      check("b2b_rsp1", 64'(bus.rsp_valid), 64'd1);
      check("b2b_q1", bus.rsp_quotient, 64'd30);
      check("b2b_gap", 64'(bus.div_valid_in), 64'd0);
      step();
      check("b2b_ready_d2", 64'(bus.req_ready), 64'd1);
      step();
      bus.req_valid = '0;
      check("b2b_vin2", 64'(bus.div_valid_in), 64'd1);
      check("b2b_dividend2", bus.div_dividend, 64'd901);
      wait_rsp(0, 64'd450, 32'd1, 1'b0);

      // Reset two cycles after acceptance, while the divider is still busy.
      div_lat = 10;
      bus.req_dividend[2*A_W +: A_W] = 64'd5000;
      bus.req_divisor[2*B_W +: B_W]  = 32'd7;
      bus.req_valid = 4'b0100;
      wait_ready(g);
      check("mid_grant", 64'(g), 64'd4);
      step();
      bus.req_valid = '0;
      step();
      reset = 1'b0;
      step();
      check_reset("midrst");
      step();
      reset = 1'b1;
      div_lat = 3;
      saw = 1'b0;
      repeat (15) begin
         step();
         if (bus.rsp_valid != '0 || bus.busy) saw = 1'b1;
      end
      check("midrst_no_rsp", 64'(saw), 64'd0);

      // Pointer back at 0: req 0 beats req 3.
      bus.req_dividend[0 +: A_W] = 64'd81;
      bus.req_divisor[0 +: B_W]  = 32'd9;
      bus.req_dividend[3*A_W +: A_W] = 64'd10;
      bus.req_divisor[3*B_W +: B_W]  = 32'd3;
      bus.req_valid = 4'b1001;
      wait_ready(g);
      check("post_rst_grant", 64'(g), 64'd1);
      step();
      bus.req_valid = '0;
      wait_rsp(0, 64'd9, 32'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/div_arbiter.md
# div_arbiter

Round-robin controller that shares one multi-cycle `div` instance (64-bit dividend, 32-bit divisor) among NUM_REQ requesters in the FM demodulator datapath, such as per-channel gain normalisation and phase scaling. It accepts one request at a time, drives the divider's valid_in/operand handshake until valid_out returns, and routes quotient, remainder and overflow back to the owning requester. Zero divisors are trapped locally and never issued to the divider.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DIVIDEND_WIDTH, 64, dividend and quotient width
- DIVISOR_WIDTH, 32, divisor and remainder width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-low (asserted when 0)
- req_valid  in  NUM_REQ  per-requester request; held until accepted
- req_ready  out  NUM_REQ  one-hot; high for the requester accepted this cycle
- req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  packed; requester i at slice i
- req_divisor  in  NUM_REQ*DIVISOR_WIDTH  packed; requester i at slice i
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- rsp_quotient  out  DIVIDEND_WIDTH  shared result bus
- rsp_remainder  out  DIVISOR_WIDTH  shared result bus
- rsp_overflow  out  1  shared; divider overflow or trapped zero divisor
- div_valid_in  out  1  to divider valid_in
- div_dividend  out  DIVIDEND_WIDTH  to divider, registered
- div_divisor  out  DIVISOR_WIDTH  to divider, registered
- div_valid_out  in  1  from divider
- div_quotient  in  DIVIDEND_WIDTH  from divider
- div_remainder  in  DIVISOR_WIDTH  from divider
- div_overflow  in  1  from divider
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NUM_REQ)  index of current or last owner

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: the round-robin pointer `ptr` selects the first requester with req_valid high, scanning ptr, ptr+1 … mod NUM_REQ. req_ready for the selected requester is combinational (IDLE and req_valid). At the accepting edge:
  - Operands are latched into div_dividend and div_divisor.
  - grant_id is set to the winner; ptr is set to winner+1 mod NUM_REQ.
  - Divisor ≠ 0: go to ISSUE.
  - Divisor = 0: load the result registers with quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], overflow = 1, then go to RESP. The divider is not started.
- ISSUE: div_valid_in = 1 with operands stable. On an edge where div_valid_out = 1, capture div_quotient, div_remainder and div_overflow, then go to RESP. There is no timeout.
- RESP: rsp_valid[grant_id] = 1 for exactly one cycle with the registered results; div_valid_in = 0. Go to IDLE.
- No arbitration while busy. req_ready is 0 in ISSUE and RESP.
- A requester may drop req_valid before it is accepted. It is simply not granted.
- Results hold on the rsp buses until the next RESP. Only the rsp_valid bit qualifies them.

## Timing
- Reset (reset = 0 at an edge):
  - State goes to IDLE and ptr to 0.
  - req_ready, rsp_valid, div_valid_in, busy and rsp_overflow are 0.
  - rsp_quotient, rsp_remainder, div_dividend, div_divisor and grant_id are 0.
- Reset mid-operation aborts with no response. div_valid_in is 0 from the edge after reset is sampled low. The divider shares the same reset.
- Normal request accepted at edge T:
  - div_valid_in goes high in cycle T+1.
  - If div_valid_out is sampled at edge D, rsp_valid is high in the cycle after D.
  - IDLE follows one cycle later, so the earliest next accept is edge D+2.
- div_valid_in is low for at least one cycle (RESP) between consecutive operations.
- Zero divisor accepted at T: rsp_valid is high in cycle T+1, and accepts resume at T+2.
- Simultaneous requests: only one is accepted per operation. With all requesters continuously requesting, each is served once per NUM_REQ operations.
- If div_valid_out is asserted outside ISSUE, it is ignored.

## Test plan
- Single request: req 0 sends 253/2 → div_valid_in rises the cycle after req_ready[0]. Expect rsp_valid[0] high for one cycle with quotient 126, remainder 1, overflow 0. busy falls the following cycle.
- Contention: reqs 0–3 all assert at once and hold, operands i*100+7 / 3 → grant order 0, 1, 2, 3. Each rsp_valid is one-hot with the correct quotient (2, 35, 69, 102).
- Fairness: req 1 re-asserts immediately after each response while req 3 holds → grants alternate 1, 3, 1, 3. Neither requester is starved.
- Zero divisor: req 2 sends dividend 0x1_0000_0005 / 0 → div_valid_in never rises. In the cycle after acceptance, rsp_valid[2] = 1, quotient all ones, remainder 5, overflow 1.
- Reset mid-ISSUE: pull reset low two cycles after acceptance → all outputs return to reset values, no rsp_valid, ptr = 0. The next request, from req 0, completes normally.
- Back-to-back: requester 0 keeps req_valid high with new operands → the second acceptance comes exactly two cycles after div_valid_out. div_valid_in shows a one-cycle low gap.
